// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between axi4_lite_master and a slave.
// Master drives the valids, addresses, write data and the response readies.
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    modport Master (
        output aw_valid, aw_addr, w_valid, w_data, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp,
               ar_ready, r_valid, r_data, r_resp
    );

    modport Slave (
        input  aw_valid, aw_addr, w_valid, w_data, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp,
               ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Define AXI_MASTER_TIMEOUT_EN to add a per-state watchdog of TIMEOUT_CYCLES cycles.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | aw/w valids presented, waiting for both handshakes
// WR_RESP | b_ready high, waiting for the write response
// RD_REQ  | ar_valid presented, waiting for the address handshake
// RD_DATA | r_ready high, waiting for read data
// RSP     | rsp_valid held until the consumer takes it
module axi4_lite_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    AXI_BUS.Master                amba_master
);

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        WR_REQ  = 6'b000010,
        WR_RESP = 6'b000100,
        RD_REQ  = 6'b001000,
        RD_DATA = 6'b010000,
        RSP     = 6'b100000
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  aw_done, w_done;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_active;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_addr_q   <= aw_addr_d;
            ar_addr_q   <= ar_addr_d;
            w_data_q    <= w_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
    end
`endif

    // A handshake counts as done once its valid has already dropped.
    assign aw_done = !aw_valid_q || amba_master.aw_ready;
    assign w_done  = !w_valid_q  || amba_master.w_ready;

    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_addr_d   = aw_addr_q;
        ar_addr_d   = ar_addr_q;
        w_data_d    = w_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_write) begin
                        aw_addr_d  = cmd_addr;
                        w_data_d   = cmd_wdata;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_addr_d  = cmd_addr;
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_valid_q && amba_master.aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && amba_master.w_ready)   w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (amba_master.b_valid && b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_err_d   = (amba_master.b_resp != 2'b00);
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (ar_valid_q && amba_master.ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (amba_master.r_valid && r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_rdata_d = amba_master.r_data;
                    rsp_err_d   = (amba_master.r_resp != 2'b00);
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // Counter restarts on every state change; expiry only fires if the state made no progress.
        wd_active = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_DATA);
        wd_cnt_d  = '0;
        if (wd_active && (state_d == state_q)) begin
            if (wd_cnt_q == WD_LAST) begin
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif

        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready            = cmd_ready_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_err              = rsp_err_q;
    assign rsp_rdata            = rsp_rdata_q;
    assign amba_master.aw_valid = aw_valid_q;
    assign amba_master.aw_addr  = aw_addr_q;
    assign amba_master.w_valid  = w_valid_q;
    assign amba_master.w_data   = w_data_q;
    assign amba_master.b_ready  = b_ready_q;
    assign amba_master.ar_valid = ar_valid_q;
    assign amba_master.ar_addr  = ar_addr_q;
    assign amba_master.r_ready  = r_ready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master; the slave side is driven by hand from the stimulus.
// Define AXI_MASTER_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_axi4_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
    logic [9:0]  wr_addr_m = '0, rd_addr_m = '0;
    logic [31:0] wr_data_m = '0;

    AXI_BUS #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    axi4_lite_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .amba_master(bus)
    );

    always #5 clk = ~clk;

    // Tiny slave memory: remembers the last write and serves it back on a matching read.
    always @(posedge clk) begin
        if (bus.aw_valid && bus.aw_ready) begin aw_hs <= aw_hs + 1; wr_addr_m <= bus.aw_addr; end
        if (bus.w_valid && bus.w_ready)   begin w_hs  <= w_hs + 1;  wr_data_m <= bus.w_data;  end
        if (bus.b_valid && bus.b_ready)   b_hs <= b_hs + 1;
        if (bus.ar_valid && bus.ar_ready) begin ar_hs <= ar_hs + 1; rd_addr_m <= bus.ar_addr; end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_clr", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_aw_valid"}, bus.aw_valid, 0);
        check({tag, "_w_valid"},  bus.w_valid, 0);
        check({tag, "_ar_valid"}, bus.ar_valid, 0);
        check({tag, "_b_ready"},  bus.b_ready, 0);
        check({tag, "_r_ready"},  bus.r_ready, 0);
        check({tag, "_aw_addr"},  bus.aw_addr, 0);
        check({tag, "_ar_addr"},  bus.ar_addr, 0);
        check({tag, "_w_data"},   bus.w_data, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err"},   rsp_err, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "bench time limit");
    end

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = 2'b00;
        bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = '0; bus.r_resp = 2'b00;

        #12;
        check_bus_idle("rst");
        #1 rst_n = 1'b1;
        tick();
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Write 0x004 <- 0xDEADBEEF, AW accepted one cycle before W.
        issue(1'b1, 10'h004, 32'hDEADBEEF);
        check("wr_aw_valid", bus.aw_valid, 1);
        check("wr_w_valid", bus.w_valid, 1);
        check("wr_aw_addr", bus.aw_addr, 10'h004);
        check("wr_w_data", bus.w_data, 32'hDEADBEEF);
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        check("wr_aw_drop", bus.aw_valid, 0);
        check("wr_w_hold", bus.w_valid, 1);
        check("wr_w_data_stable", bus.w_data, 32'hDEADBEEF);
        check("wr_b_ready_early", bus.b_ready, 0);
        bus.w_ready = 1'b1;
        tick();
        bus.w_ready = 1'b0;
        check("wr_w_drop", bus.w_valid, 0);
        check("wr_b_ready", bus.b_ready, 1);
        bus.b_valid = 1'b1; bus.b_resp = 2'b00;
        tick();
        bus.b_valid = 1'b0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_b_ready_drop", bus.b_ready, 0);
        finish_rsp();
        check("wr_aw_hs", aw_hs, 1);
        check("wr_w_hs", w_hs, 1);
        check("wr_b_hs", b_hs, 1);

        // Read back 0x004 with two AR wait states, then hold rsp_ready low for 5 cycles.
        issue(1'b0, 10'h004, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("rd_ar_valid", bus.ar_valid, 1);
            check("rd_ar_addr", bus.ar_addr, 10'h004);
            if (i == 2) bus.ar_ready = 1'b1;
            tick();
        end
        bus.ar_ready = 1'b0;
        check("rd_ar_drop", bus.ar_valid, 0);
        check("rd_r_ready", bus.r_ready, 1);
        check("rd_ar_hs", ar_hs, 1);
        bus.r_valid = 1'b1; bus.r_resp = 2'b00;
        bus.r_data = (rd_addr_m == wr_addr_m) ? wr_data_m : 32'h0;
        tick();
        bus.r_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_valid", rsp_valid, 1);
            check("rd_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("rd_hold_err", rsp_err, 0);
            check("rd_hold_cmd_ready", cmd_ready, 0);
            tick();
        end
        finish_rsp();

        // Read with SLVERR response.
        issue(1'b0, 10'h008, 32'h0);
        bus.ar_ready = 1'b1;
        tick();
        bus.ar_ready = 1'b0;
        bus.r_valid = 1'b1; bus.r_data = 32'h12345678; bus.r_resp = 2'b10;
        tick();
        bus.r_valid = 1'b0; bus.r_resp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_rsp_err", rsp_err, 1);
            check("err_rsp_rdata", rsp_rdata, 32'h12345678);
            check("err_cmd_ready", cmd_ready, 0);
            tick();
        end
        finish_rsp();

        // Zero-wait write, AW and W together, DECERR: rsp_valid two edges after accept.
        bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b1; bus.b_resp = 2'b11;
        issue(1'b1, 10'h3FC, 32'hA5A5_0F0F);
        check("zw_aw_valid", bus.aw_valid, 1);
        check("zw_w_valid", bus.w_valid, 1);
        tick();
        check("zw_both_drop", {bus.aw_valid, bus.w_valid}, 2'b00);
        check("zw_b_ready", bus.b_ready, 1);
        check("zw_rsp_early", rsp_valid, 0);
        tick();
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
        check("zw_rsp_valid", rsp_valid, 1);
        check("zw_rsp_err", rsp_err, 1);
        check("zw_rsp_rdata", rsp_rdata, 0);
        finish_rsp();
        check("zw_aw_hs", aw_hs, 2);
        check("zw_w_hs", w_hs, 2);

        // W accepted before AW.
        issue(1'b1, 10'h010, 32'h0BAD_F00D);
        bus.w_ready = 1'b1;
        tick();
        bus.w_ready = 1'b0;
        check("wa_w_drop", bus.w_valid, 0);
        check("wa_aw_hold", bus.aw_valid, 1);
        check("wa_aw_addr", bus.aw_addr, 10'h010);
        bus.aw_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0;
        check("wa_b_ready", bus.b_ready, 1);
        bus.b_valid = 1'b1;
        tick();
        bus.b_valid = 1'b0;
        check("wa_rsp_err", rsp_err, 0);
        finish_rsp();

        // Reset pulse while in WR_RESP.
        issue(1'b1, 10'h020, 32'hCAFE_F00D);
        bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
        tick();
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        check("rwr_b_ready", bus.b_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check_bus_idle("rwr");
        tick();
        check("rwr_held_cmd_ready", cmd_ready, 0);
        #1 rst_n = 1'b1;
        tick();
        check("rwr_cmd_ready", cmd_ready, 1);
        check("rwr_rsp_valid", rsp_valid, 0);
        tick();
        check("rwr_rsp_valid2", rsp_valid, 0);
        check("rwr_b_ready2", bus.b_ready, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // AR never accepted: ar_valid high for exactly 8 cycles, then error response.
        issue(1'b0, 10'h040, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("to_ar_valid", bus.ar_valid, 1);
            tick();
        end
        check("to_ar_drop", bus.ar_valid, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        finish_rsp();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
